updown_counter_p: RTL and testbench

UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

---
 rtl/updown_pkg.sv | 6 +
 rtl/updown_next.sv | 38 +++
 rtl/updown_counter_p.sv | 60 ++++++
 tb/tb_updown_counter_p.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// updown_pkg: direction constants and next-value selector shared by the up/down counter.
package updown_pkg;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
    typedef enum logic [2:0] {HOLD, INC, DEC, LOAD, WRAP_LO, WRAP_HI} nxt_sel_e;
endpackage

// File: rtl/updown_next.sv
// updown_next: combinational next-count, wrap and load-error decode for updown_counter_p.
module updown_next
    import updown_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] count_d_o,
    output logic             wrap_d_o,
    output logic             err_set_o
);
    logic     at_max, at_zero, up, oor;
    nxt_sel_e sel;
    assign at_max  = count_i == MAX_VAL;
    assign at_zero = count_i == '0;
    assign up      = mode_i == DIR_UP;
    assign oor     = load_val_i > MAX_VAL;
    // Saturation reuses HOLD at the boundary while still flagging wrap.
    always_comb begin
        sel = load_i ? LOAD :
              !en_i  ? HOLD :
              up     ? (at_max  ? (sat_i ? HOLD : WRAP_LO) : INC) :
                       (at_zero ? (sat_i ? HOLD : WRAP_HI) : DEC);
        count_d_o = sel == LOAD    ? (oor ? MAX_VAL : load_val_i) :
                    sel == INC     ? count_i + 1'b1 :
                    sel == DEC     ? count_i - 1'b1 :
                    sel == WRAP_LO ? '0 :
                    sel == WRAP_HI ? MAX_VAL : count_i;
        wrap_d_o  = !load_i && en_i && (up ? at_max : at_zero);
        err_set_o = load_i && oor;
    end
endmodule

// File: rtl/updown_counter_p.sv
// updown_counter_p: bounded up/down counter with load, wrap pulse and sticky load error.
// Define UPDN_SAT_EN to add the sat input that saturates instead of wrapping.
module updown_counter_p
    import updown_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
`ifdef UPDN_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             err
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d, err_q, err_d, err_set, sat_w;
`ifdef UPDN_SAT_EN
    assign sat_w = sat;
`else
    assign sat_w = 1'b0;
`endif
    updown_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_next (
        .count_i   (count_q),
        .en_i      (en),
        .mode_i    (mode),
        .load_i    (load),
        .load_val_i(load_val),
        .sat_i     (sat_w),
        .count_d_o (count_d),
        .wrap_d_o  (wrap_d),
        .err_set_o (err_set)
    );
    // A new out-of-range load wins over a simultaneous clear.
    assign err_d = err_set || (err_q && !clr_err);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end
    assign count = count_q;
    assign wrap  = wrap_q;
    assign err   = err_q;
    assign tc    = mode == DIR_UP ? count_q == MAX_VAL : count_q == '0;
endmodule

// File: tb/tb_updown_counter_p.sv
// tb_updown_counter_p: directed checks of updown_counter_p (MAX_VAL=9 and MAX_VAL=1 instances).
module tb_updown_counter_p;
    logic       clk = 0, rst = 1, en = 0, mode = 1, load = 0, clr_err = 0;
    logic [3:0] load_val = 0, count;
    logic       tc, wrap, err;
    logic       rst1 = 1, en1 = 0, tc1, wrap1, err1;
    logic [1:0] count1;
    int         errors = 0, checks = 0;
`ifdef UPDN_SAT_EN
    logic sat = 0;
`endif

    always #5 clk = ~clk;

    updown_counter_p #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .clr_err(clr_err),
`ifdef UPDN_SAT_EN
        .sat(sat),
`endif
        .count(count), .tc(tc), .wrap(wrap), .err(err)
    );

    updown_counter_p #(.WIDTH(2), .MAX_VAL(2'd1), .RST_VAL(2'd0)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(1'b1), .load(1'b0),
        .load_val(2'd0), .clr_err(1'b0),
`ifdef UPDN_SAT_EN
        .sat(1'b0),
`endif
        .count(count1), .tc(tc1), .wrap(wrap1), .err(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks += 4;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
        rst = 0;
    endtask

    task automatic test_count_up();
        int exp;
        en = 1;
        mode = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = (i + 1) % 10;
            checks += 3;
            if (count !== 4'(exp)) begin errors++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count, exp); end
            if (wrap !== (i == 9)) begin errors++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap, i == 9); end
            if (tc !== (exp == 9)) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc, exp == 9); end
        end
        en = 0;
    endtask

    task automatic test_count_down();
        logic [3:0] exp [3] = '{4'd9, 4'd8, 4'd7};
        load = 1;
        load_val = 0;
        mode = 0;
        tick();
        load = 0;
        checks += 2;
        if (count !== 4'd0) begin errors++; $display("FAIL dn_load0 got=%0d exp=0", count); end
        if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc0 got=%b exp=1", tc); end
        en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (count !== exp[i]) begin errors++; $display("FAIL dn_count[%0d] got=%0d exp=%0d", i, count, exp[i]); end
            if (wrap !== (i == 0)) begin errors++; $display("FAIL dn_wrap[%0d] got=%b exp=%b", i, wrap, i == 0); end
            if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc[%0d] got=%b exp=0", i, tc); end
        end
        en = 0;
        mode = 1;
    endtask

    task automatic test_load();
        en = 1;
        mode = 1;
        load = 1;
        load_val = 5;
        tick();
        checks += 2;
        if (count !== 4'd5) begin errors++; $display("FAIL ld5_count got=%0d exp=5", count); end
        if (err !== 1'b0) begin errors++; $display("FAIL ld5_err got=%b exp=0", err); end
        load_val = 12;
        tick();
        checks += 2;
        if (count !== 4'd9) begin errors++; $display("FAIL ld12_count got=%0d exp=9", count); end
        if (err !== 1'b1) begin errors++; $display("FAIL ld12_err got=%b exp=1", err); end
        load_val = 9;
        tick();
        checks += 3;
        if (count !== 4'd9) begin errors++; $display("FAIL ld9_count got=%0d exp=9", count); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL ld9_wrap got=%b exp=0", wrap); end
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        load = 0;
        en = 0;
        clr_err = 1;
        tick();
        checks += 1;
        if (err !== 1'b0) begin errors++; $display("FAIL clr_err got=%b exp=0", err); end
        load = 1;
        load_val = 15;
        tick();
        checks += 1;
        if (err !== 1'b1) begin errors++; $display("FAIL clr_vs_set got=%b exp=1", err); end
        load = 0;
        tick();
        checks += 1;
        if (err !== 1'b0) begin errors++; $display("FAIL clr_again got=%b exp=0", err); end
        clr_err = 0;
    endtask

    task automatic test_async_reset();
        load = 1;
        load_val = 13;
        tick();
        load_val = 6;
        tick();
        load = 0;
        checks += 2;
        if (count !== 4'd6) begin errors++; $display("FAIL ar_pre_count got=%0d exp=6", count); end
        if (err !== 1'b1) begin errors++; $display("FAIL ar_pre_err got=%b exp=1", err); end
        en = 1;
        mode = 1;
        #2 rst = 1;
        #1;
        checks += 3;
        if (count !== 4'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", count); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL ar_wrap got=%b exp=0", wrap); end
        if (err !== 1'b0) begin errors++; $display("FAIL ar_err got=%b exp=0", err); end
        #1 rst = 0;
        tick();
        checks += 2;
        if (count !== 4'd1) begin errors++; $display("FAIL ar_resume got=%0d exp=1", count); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL ar_resume_wrap got=%b exp=0", wrap); end
        en = 0;
    endtask

`ifdef UPDN_SAT_EN
    task automatic test_sat();
        load = 1;
        load_val = 8;
        tick();
        load = 0;
        sat = 1;
        en = 1;
        mode = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (count !== 4'd9) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=9", i, count); end
            if (wrap !== (i != 0)) begin errors++; $display("FAIL sat_wrap[%0d] got=%b exp=%b", i, wrap, i != 0); end
        end
        sat = 0;
        tick();
        checks += 2;
        if (count !== 4'd0) begin errors++; $display("FAIL unsat_count got=%0d exp=0", count); end
        if (wrap !== 1'b1) begin errors++; $display("FAIL unsat_wrap got=%b exp=1", wrap); end
        en = 0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [1:0] exp [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        rst1 = 0;
        en1 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (count1 !== exp[i]) begin errors++; $display("FAIL m1_count[%0d] got=%0d exp=%0d", i, count1, exp[i]); end
            if (wrap1 !== (i % 2 == 1)) begin errors++; $display("FAIL m1_wrap[%0d] got=%b exp=%b", i, wrap1, i % 2 == 1); end
        end
        en1 = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_async_reset();
`ifdef UPDN_SAT_EN
        test_sat();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
